// File: rtl/uart_pkg.sv
// Shared types and constants for the serial MMIO UART.
//   tx_state_t / rx_state_t : frame FSM states
//   UART_DATA_WADDR        : word address of the RX/TX data register
//   UART_STAT_WADDR        : word address of the status register
//   SEND_BIT / RECV_BIT    : bit positions inside the status word
package uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [31:0] UART_DATA_WADDR = 32'h07F4_00FE;
   localparam logic [31:0] UART_STAT_WADDR = 32'h07F4_00FF;

   localparam int SEND_BIT = 0;
   localparam int RECV_BIT = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// TX byte queue, DEPTH x 8, full/empty derived from an occupancy count.
//   clk, rst  : clock, async active-high reset
//   push      : enqueue wdata (ignored when full unless a pop frees a slot)
//   wdata     : byte to enqueue
//   pop       : dequeue the head entry (ignored when empty)
//   rdata     : head entry, valid while empty = 0
//   empty     : no entries queued
//   not_full  : registered, 1 while count != DEPTH
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       empty,
   output logic       not_full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic          do_push;
   logic          do_pop;

   assign empty  = (count == '0);
   assign rdata  = mem[rd_ptr];
   assign do_pop = pop && !empty;
   // a pop in the same cycle frees the slot, so a push on a full queue still lands
   assign do_push = push && ((count != FULL_CNT) || do_pop);

   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + (AW + 1)'(1);
      end else if (!do_push && do_pop) begin
         count_next = count - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         not_full <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count    <= count_next;
         not_full <= (count_next != FULL_CNT);
      end
   end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// UART peripheral behind the mem-stage serial MMIO window. 8N1, LSB first.
//   clk, rst        : core clock, async active-high reset
//   uart_wdata      : TX byte, queued when uart_write_ce = 1
//   uart_write_ce   : 1-cycle write strobe
//   clean_recv_flag : level, clears recv_flag every cycle it is high
//   uart_rdata      : last received byte
//   recv_flag       : unread RX byte present
//   send_flag       : TX queue can accept a byte
//   txd             : serial out, idle high
//   rxd             : serial in, asynchronous to clk
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line idle, waiting for a queued byte
//   TX_START | start bit (low)
//   TX_DATA  | 8 data bits, LSB first
//   TX_STOP  | stop bit (high); chains straight into the next frame
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on rxd_s
//   RX_START | half-bit wait, then confirm start bit is still low
//   RX_DATA  | mid-bit sample of 8 data bits
//   RX_STOP  | mid-bit sample of stop bit; commit byte if high
module uart_mmio_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600,
   parameter int TX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] uart_wdata,
   input  logic       uart_write_ce,
   input  logic       clean_recv_flag,
   output logic [7:0] uart_rdata,
   output logic       recv_flag,
   output logic       send_flag,
   output logic       txd,
   input  logic       rxd
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

   logic       fifo_pop;
   logic [7:0] fifo_data;
   logic       fifo_empty;

   uart_tx_fifo #(
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (uart_write_ce),
      .wdata    (uart_wdata),
      .pop      (fifo_pop),
      .rdata    (fifo_data),
      .empty    (fifo_empty),
      .not_full (send_flag)
   );

   tx_state_t     tx_state;
   logic [BW-1:0] tx_baud;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;

   // the next byte is taken either from idle or at the last cycle of a stop bit
   assign fifo_pop = !fifo_empty &&
                     ((tx_state == TX_IDLE) ||
                      ((tx_state == TX_STOP) && (tx_baud == '0)));

   // txd is driven from the current state, so it trails the state by one edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_baud  <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         txd      <= 1'b1;
      end else begin
         case (tx_state)
            TX_START: txd <= 1'b0;
            TX_DATA:  txd <= tx_shift[0];
            default:  txd <= 1'b1;
         endcase

         case (tx_state)
            TX_IDLE: begin
               if (fifo_pop) begin
                  tx_shift <= fifo_data;
                  tx_baud  <= BIT_LAST;
                  tx_bit   <= '0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_baud == '0) begin
                  tx_baud  <= BIT_LAST;
                  tx_state <= TX_DATA;
               end else begin
                  tx_baud <= tx_baud - BW'(1);
               end
            end
            TX_DATA: begin
               if (tx_baud == '0) begin
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_bit   <= tx_bit + 3'd1;
                  tx_baud  <= BIT_LAST;
                  if (tx_bit == 3'd7) begin
                     tx_state <= TX_STOP;
                  end
               end else begin
                  tx_baud <= tx_baud - BW'(1);
               end
            end
            TX_STOP: begin
               if (tx_baud == '0) begin
                  if (fifo_pop) begin
                     tx_shift <= fifo_data;
                     tx_baud  <= BIT_LAST;
                     tx_bit   <= '0;
                     tx_state <= TX_START;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_baud <= tx_baud - BW'(1);
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   logic          rxd_m;
   logic          rxd_s;
   logic          rxd_s_d;
   rx_state_t     rx_state;
   logic [BW-1:0] rx_baud;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_done;

   assign rx_done = (rx_state == RX_STOP) && (rx_baud == '0) && rxd_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_m      <= 1'b1;
         rxd_s      <= 1'b1;
         rxd_s_d    <= 1'b1;
         rx_state   <= RX_IDLE;
         rx_baud    <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         uart_rdata <= '0;
         recv_flag  <= 1'b0;
      end else begin
         rxd_m   <= rxd;
         rxd_s   <= rxd_m;
         rxd_s_d <= rxd_s;

         // a completing frame beats a clear in the same cycle
         if (rx_done) begin
            recv_flag <= 1'b1;
         end else if (clean_recv_flag) begin
            recv_flag <= 1'b0;
         end

         case (rx_state)
            RX_IDLE: begin
               if (rxd_s_d && !rxd_s) begin
                  rx_baud  <= HALF_LAST;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_baud == '0) begin
                  if (rxd_s) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_baud  <= BIT_LAST;
                     rx_bit   <= '0;
                     rx_state <= RX_DATA;
                  end
               end else begin
                  rx_baud <= rx_baud - BW'(1);
               end
            end
            RX_DATA: begin
               if (rx_baud == '0) begin
                  rx_shift <= {rxd_s, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  rx_baud  <= BIT_LAST;
                  if (rx_bit == 3'd7) begin
                     rx_state <= RX_STOP;
                  end
               end else begin
                  rx_baud <= rx_baud - BW'(1);
               end
            end
            RX_STOP: begin
               if (rx_baud == '0) begin
                  if (rxd_s) begin
                     uart_rdata <= rx_shift;
                  end
                  rx_state <= RX_IDLE;
               end else begin
                  rx_baud <= rx_baud - BW'(1);
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl at CLKS_PER_BIT = 8, TX_DEPTH = 4.
// A queue-level model predicts txd, send_flag, uart_rdata and recv_flag every
// cycle; literal checks pin the model at hand-computed points.
module tb_uart_mmio_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] uart_wdata = 8'h00;
   logic       uart_write_ce = 1'b0;
   logic       clean_recv_flag = 1'b0;
   logic [7:0] uart_rdata;
   logic       recv_flag;
   logic       send_flag;
   logic       txd;
   logic       rxd = 1'b1;

   int checks = 0;
   int errors = 0;
   logic run = 1'b0;

   uart_mmio_ctrl #(
      .CLK_FREQ (800),
      .BAUD     (100),
      .TX_DEPTH (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .uart_wdata      (uart_wdata),
      .uart_write_ce   (uart_write_ce),
      .clean_recv_flag (clean_recv_flag),
      .uart_rdata      (uart_rdata),
      .recv_flag       (recv_flag),
      .send_flag       (send_flag),
      .txd             (txd),
      .rxd             (rxd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a byte queue of depth 4 and a queue of expected per-edge txd values.
   // A frame popped at edge P shows its 80 line values on edges P+1..P+80; the
   // next pop may happen on edge P+80 (no gap). The RX side is told by the
   // stimulus which edge commits a byte (rx_pend).
   logic [7:0] m_fifo[$];
   logic       m_wave[$];
   logic       m_txd   = 1'b1;
   logic [7:0] m_rdata = 8'h00;
   logic       m_recv  = 1'b0;
   logic       rx_pend = 1'b0;
   logic [7:0] rx_pend_byte = 8'h00;

   logic       m_pop;
   logic [9:0] m_frame;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_fifo.delete();
         m_wave.delete();
         m_txd   = 1'b1;
         m_rdata = 8'h00;
         m_recv  = 1'b0;
      end else begin
         m_pop = (m_wave.size() <= 1) && (m_fifo.size() > 0);
         m_txd = (m_wave.size() > 0) ? m_wave.pop_front() : 1'b1;
         if (m_pop) begin
            m_frame = {1'b1, m_fifo.pop_front(), 1'b0};
            for (int k = 0; k < 80; k++) m_wave.push_back(m_frame[k / 8]);
         end
         if (uart_write_ce && (m_fifo.size() < 4)) m_fifo.push_back(uart_wdata);
         if (rx_pend) begin
            m_rdata = rx_pend_byte;
            m_recv  = 1'b1;
         end else if (clean_recv_flag) begin
            m_recv = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         check("txd", 32'(txd), 32'(m_txd));
         check("send_flag", 32'(send_flag), 32'(m_fifo.size() != 4));
         check("uart_rdata", 32'(uart_rdata), 32'(m_rdata));
         check("recv_flag", 32'(recv_flag), 32'(m_recv));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic write_byte(input logic [7:0] b);
      uart_wdata    = b;
      uart_write_ce = 1'b1;
      tick();
      uart_write_ce = 1'b0;
   endtask

   // Drives one 8-clk-per-bit frame; the stop mid-sample commits on edge 78
   // counted from the first edge that samples the start bit.
   task automatic send_rx(input logic [7:0] b, input logic stop, input logic hold_clean);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int c = 0; c < 80; c++) begin
         rxd          = f[c / 8];
         rx_pend      = (c == 78) && stop;
         rx_pend_byte = b;
         if (hold_clean) clean_recv_flag = (c < 79);
         tick();
      end
      rxd     = 1'b1;
      rx_pend = 1'b0;
      repeat (4) tick();
   endtask

   logic [9:0] exp55;
   logic [9:0] rst_frame;

   initial begin
      exp55 = 10'b1010101010;
      repeat (3) tick();
      check("reset_txd", 32'(txd), 32'd1);
      check("reset_rdata", 32'(uart_rdata), 32'h00);
      check("reset_recv", 32'(recv_flag), 32'd0);
      check("reset_send", 32'(send_flag), 32'd1);
      rst = 1'b0;
      run = 1'b1;
      repeat (3) tick();

      // 1: single byte 0x55, start bit appears two edges after the strobe edge
      write_byte(8'h55);
      tick();
      check("t1_before_start", 32'(txd), 32'd1);
      tick();
      check("t1_start_fall", 32'(txd), 32'd0);
      repeat (4) tick();
      for (int k = 0; k < 10; k++) begin
         check("t1_bit", 32'(txd), 32'(exp55[k]));
         repeat (8) tick();
      end
      repeat (10) tick();

      // 2: six back-to-back writes, sixth is dropped
      uart_write_ce = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         uart_wdata = 8'(i);
         tick();
         if (i == 5) check("t2_full_after_5", 32'(send_flag), 32'd0);
      end
      uart_write_ce = 1'b0;
      check("t2_full_after_6", 32'(send_flag), 32'd0);
      repeat (76) tick();
      check("t2_stop_of_first", 32'(txd), 32'd1);
      tick();
      check("t2_b2b_start", 32'(txd), 32'd0);
      check("t2_slot_free", 32'(send_flag), 32'd1);
      repeat (340) tick();

      // 3: receive 0xA3, then clear
      send_rx(8'hA3, 1'b1, 1'b0);
      check("t3_rdata", 32'(uart_rdata), 32'hA3);
      check("t3_recv", 32'(recv_flag), 32'd1);
      clean_recv_flag = 1'b1;
      tick();
      clean_recv_flag = 1'b0;
      tick();
      check("t3_cleared", 32'(recv_flag), 32'd0);
      check("t3_rdata_hold", 32'(uart_rdata), 32'hA3);

      // 4: framing error, then a 2-clk glitch
      send_rx(8'h3C, 1'b0, 1'b0);
      check("t4_ferr_recv", 32'(recv_flag), 32'd0);
      check("t4_ferr_rdata", 32'(uart_rdata), 32'hA3);
      rxd = 1'b0;
      repeat (2) tick();
      rxd = 1'b1;
      repeat (20) tick();
      check("t4_glitch_recv", 32'(recv_flag), 32'd0);
      check("t4_glitch_rdata", 32'(uart_rdata), 32'hA3);

      // 5: set beats a held clear, then overrun
      send_rx(8'h7E, 1'b1, 1'b1);
      check("t5_set_wins", 32'(recv_flag), 32'd1);
      check("t5_rdata", 32'(uart_rdata), 32'h7E);
      send_rx(8'h81, 1'b1, 1'b0);
      check("t5_overrun_rdata", 32'(uart_rdata), 32'h81);
      check("t5_overrun_recv", 32'(recv_flag), 32'd1);

      // 6: reset in the middle of a TX frame and an RX frame
      rst_frame = {1'b1, 8'hF0, 1'b0};
      rxd = 1'b0;
      write_byte(8'h99);
      write_byte(8'h11);
      for (int c = 2; c < 40; c++) begin
         rxd = rst_frame[c / 8];
         tick();
      end
      check("t6_tx_busy", 32'(send_flag), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_txd", 32'(txd), 32'd1);
      check("t6_rst_send", 32'(send_flag), 32'd1);
      check("t6_rst_recv", 32'(recv_flag), 32'd0);
      check("t6_rst_rdata", 32'(uart_rdata), 32'h00);
      rxd = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      write_byte(8'h5A);
      repeat (100) tick();
      send_rx(8'hC4, 1'b1, 1'b0);
      check("t6_rx_after_rst", 32'(uart_rdata), 32'hC4);
      check("t6_recv_after_rst", 32'(recv_flag), 32'd1);
      repeat (5) tick();

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
